rmii_rx: RTL and testbench
==========================

# rmii_rx

Receive-side RMII deserializer between the LAN8720 PHY and `eth_parser`. It samples the 2-bit RMII receive bus at 50 MHz (100 Mbps mode only) and locks onto the preamble/SFD. It assembles dibits LSB-first into bytes and presents them on the `received_byte`/`byte_valid` stream that `eth_parser` consumes, starting with the SFD byte 0xD5. It also flags frame end, frame length and receive errors.

## Interface
- `MIN_PREAMBLE_DIBITS`, 12: minimum consecutive `01` dibits required before the SFD `11` dibit. Range 1–31.
- `MAX_FRAME_BYTES`, 1522: maximum bytes after the SFD (header through FCS) before overflow.

- `clk`  in  1  50 MHz RMII reference clock. Single clock domain; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rmii_rxd`  in  2  RMII RXD[1:0]. Already synchronous to `clk`.
- `rmii_crs_dv`  in  1  RMII CRS_DV.
- `received_byte`  out  8  assembled byte. Holds its value between `byte_valid` pulses.
- `byte_valid`  out  1  one-cycle pulse per byte, SFD included.
- `frame_end`  out  1  one-cycle pulse when a frame that reached DATA terminates.
- `frame_len`  out  16  bytes received after the SFD. Valid while `frame_end` is high; holds its value until the next `frame_end`.
- `rx_error`  out  1  one-cycle pulse, coincident with `frame_end`, on alignment error or overflow.

## Operation
- **Input register.** Each edge captures `{rmii_crs_dv, rmii_rxd}` into register s1.
- **Dibit processing.** Each edge processes the dibit held in s1.
  - The dibit counts as present if s1.crs_dv is high or the live `rmii_crs_dv` is high. This tolerates the PHY's end-of-frame CRS_DV toggling.
  - Carrier end = s1.crs_dv low and live `rmii_crs_dv` low, i.e. two consecutive low samples.
- **States:** IDLE, PREAMBLE, DATA, DROP.
- **Reset.** Clears the state to DROP, so the block never locks on mid-frame. All outputs, counters and s1 clear to 0.
- **DROP**
  - Ignores all dibits.
  - Carrier end → IDLE.
- **IDLE**
  - Present `01` → PREAMBLE, preamble count = 1.
  - Any other dibit, including the PHY's leading `00`s, → stay in IDLE.
- **PREAMBLE**
  - `01` → increment the preamble count, saturating at 31.
  - `11` with count ≥ MIN_PREAMBLE_DIBITS → emit `received_byte`=0xD5 with `byte_valid`, clear the dibit index and byte count, → DATA.
  - `11` with count < MIN → DROP.
  - `00` or `10` → DROP.
  - Carrier end → IDLE.
  - No outputs in any of these cases except the SFD emission.
- **DATA**
  - Present dibit → shift into the byte register. Dibit 0 fills bits [1:0], dibit 3 fills bits [7:6].
  - At dibit index 3, emit the byte with `byte_valid` and increment the byte count.
  - Carrier end with dibit index 0 → `frame_end`, `frame_len` = byte count, → IDLE.
  - Carrier end with dibit index ≠ 0 → `frame_end` + `rx_error`. The partial byte is discarded, `frame_len` = whole bytes, → IDLE.
  - Overflow: the byte that would make the count exceed MAX_FRAME_BYTES is not emitted. Instead `frame_end` + `rx_error` pulse, `frame_len` = MAX_FRAME_BYTES, → DROP.
- **Counter widths.** The byte count is 16 bits and never wraps, because overflow is caught first. The dibit index is 2 bits and wraps 3→0.

## Timing
- Dibit sampled at edge E is processed at edge E+1.
  - A byte whose 4th dibit is sampled at E has `byte_valid` high from E+1 to E+2.
  - The SFD `11` sampled at E likewise gives 0xD5 with `byte_valid` high from E+1 to E+2.
- Consecutive data bytes arrive every 4 cycles; `byte_valid` is never high on adjacent cycles.
- CRS_DV low samples at E-1 and E → `frame_end` (and `rx_error` if applicable) high from E to E+1.
- A single low CRS_DV sample between high samples does not end the frame, and its dibit is kept as data.
- `frame_end` never coincides with `byte_valid`.
- Synchronous `reset` mid-frame: outputs go to 0 on that edge, with no `frame_end`. The block resumes only after carrier end plus a fresh preamble.

## Test plan
- **Clean frame.** `00`×3, then `01`×31, `11`, then 64 bytes 0x00..0x3F LSB-dibit first, then CRS_DV low. Expect 0xD5 followed by 0x00..0x3F, 65 `byte_valid` pulses 4 cycles apart, and one `frame_end` with `frame_len`=64 and `rx_error`=0.
- **End toggling.** Same frame, but CRS_DV alternates low/high on the last 8 dibits and then goes low. Expect all bytes intact, `frame_end` exactly once (one cycle after the second consecutive low sample), `frame_len`=64.
- **Short preamble.** With MIN=12: 10×`01` then `11` and data → no `byte_valid` and no `frame_end`. A following clean frame is received correctly.
- **Alignment error.** Clean frame of 20 bytes plus 2 extra dibits, then carrier end. Expect 21 `byte_valid` pulses (SFD + 20), then `frame_end` + `rx_error` with `frame_len`=20.
- **Overflow.** With MAX_FRAME_BYTES=16, send a 20-byte frame. Expect SFD + 16 bytes, then `frame_end` + `rx_error` with `frame_len`=16, and no further `byte_valid` until the next preamble.
- **Reset mid-frame.** Assert `reset` for one cycle during byte 10 of a frame while CRS_DV stays high and a valid `01`…`11` pattern appears in the payload. Expect no output until CRS_DV has been low for two samples; the next clean frame decodes correctly.

Source files
------------

// File: rtl/rmii_rx.sv
`default_nettype none
// ============================================================================
// Module   : rmii_rx
// Function : RMII 100 Mbps receive deserializer with preamble/SFD lock, dibit
//            to byte assembly and frame end/length/error reporting.
// Revision : 1.0  initial release
// ============================================================================
module rmii_rx #(
   parameter int MIN_PREAMBLE_DIBITS = 12,
   parameter int MAX_FRAME_BYTES     = 1522
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  rmii_rxd,
   input  logic        rmii_crs_dv,
   output logic [7:0]  received_byte,
   output logic        byte_valid,
   output logic        frame_end,
   output logic [15:0] frame_len,
   output logic        rx_error
);

   localparam logic [1:0]  c_st_idle     = 2'd0;
   localparam logic [1:0]  c_st_preamble = 2'd1;
   localparam logic [1:0]  c_st_data     = 2'd2;
   localparam logic [1:0]  c_st_drop     = 2'd3;

   localparam logic [1:0]  c_dibit_pre   = 2'b01;
   localparam logic [1:0]  c_dibit_sfd   = 2'b11;
   localparam logic [7:0]  c_sfd_byte    = 8'hD5;
   localparam logic [4:0]  c_pre_sat     = 5'd31;
   localparam logic [4:0]  c_pre_min     = 5'(MIN_PREAMBLE_DIBITS);
   localparam logic [15:0] c_max_bytes   = 16'(MAX_FRAME_BYTES);

   logic        r_s1_dv;
   logic [1:0]  r_s1_rxd;
   logic [1:0]  r_state;
   logic [4:0]  r_pre_cnt;
   logic [1:0]  r_dibit_idx;
   logic [15:0] r_byte_cnt;
   logic [5:0]  r_shift;

   logic        w_present;
   logic        w_carrier_end;
   logic [7:0]  w_byte;

   // Either sample high keeps the dibit: the PHY toggles CRS_DV near frame end.
   assign w_present     = r_s1_dv | rmii_crs_dv;
   assign w_carrier_end = ~r_s1_dv & ~rmii_crs_dv;
   assign w_byte        = {r_s1_rxd, r_shift};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1_dv       <= 1'b0;
         r_s1_rxd      <= 2'b00;
         r_state       <= c_st_drop;
         r_pre_cnt     <= 5'd0;
         r_dibit_idx   <= 2'd0;
         r_byte_cnt    <= 16'd0;
         r_shift       <= 6'd0;
         received_byte <= 8'd0;
         byte_valid    <= 1'b0;
         frame_end     <= 1'b0;
         frame_len     <= 16'd0;
         rx_error      <= 1'b0;
      end else begin
         r_s1_dv    <= rmii_crs_dv;
         r_s1_rxd   <= rmii_rxd;
         byte_valid <= 1'b0;
         frame_end  <= 1'b0;
         rx_error   <= 1'b0;

         case (r_state)
            c_st_drop: begin
               if (w_carrier_end) begin
                  r_state <= c_st_idle;
               end
            end

            c_st_idle: begin
               if (w_present && r_s1_rxd == c_dibit_pre) begin
                  r_pre_cnt <= 5'd1;
                  r_state   <= c_st_preamble;
               end
            end

            c_st_preamble: begin
               if (w_carrier_end) begin
                  r_state <= c_st_idle;
               end else if (r_s1_rxd == c_dibit_pre) begin
                  if (r_pre_cnt != c_pre_sat) begin
                     r_pre_cnt <= r_pre_cnt + 5'd1;
                  end
               end else if (r_s1_rxd == c_dibit_sfd && r_pre_cnt >= c_pre_min) begin
                  received_byte <= c_sfd_byte;
                  byte_valid    <= 1'b1;
                  r_dibit_idx   <= 2'd0;
                  r_byte_cnt    <= 16'd0;
                  r_state       <= c_st_data;
               end else begin
                  r_state <= c_st_drop;
               end
            end

            c_st_data: begin
               if (w_carrier_end) begin
                  frame_end <= 1'b1;
                  frame_len <= r_byte_cnt;
                  rx_error  <= (r_dibit_idx != 2'd0);
                  r_state   <= c_st_idle;
               end else begin
                  r_shift     <= {r_s1_rxd, r_shift[5:2]};
                  r_dibit_idx <= r_dibit_idx + 2'd1;
                  if (r_dibit_idx == 2'd3) begin
                     // The byte that would exceed the limit is swallowed and the frame aborted.
                     if (r_byte_cnt == c_max_bytes) begin
                        frame_end <= 1'b1;
                        rx_error  <= 1'b1;
                        frame_len <= c_max_bytes;
                        r_state   <= c_st_drop;
                     end else begin
                        received_byte <= w_byte;
                        byte_valid    <= 1'b1;
                        r_byte_cnt    <= r_byte_cnt + 16'd1;
                     end
                  end
               end
            end

            default: begin
               r_state <= c_st_drop;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rmii_rx.sv
`default_nettype none
// tb_rmii_rx: directed RMII frames into two instances (default limit and a 16-byte limit),
// checked every cycle against a burst-level frame decoder plus literal frame summaries.
module tb_rmii_rx;

   localparam int N_MAX   = 4096;
   localparam int MIN_PRE = 12;
   localparam int MAX_A   = 1522;
   localparam int MAX_B   = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  rmii_rxd;
   logic        rmii_crs_dv;

   logic [7:0]  rb_a, rb_b;
   logic        bv_a, bv_b, fe_a, fe_b, err_a, err_b;
   logic [15:0] len_a, len_b;

   rmii_rx #(.MIN_PREAMBLE_DIBITS(MIN_PRE), .MAX_FRAME_BYTES(MAX_A)) dut_a (
      .clk(clk), .reset(reset), .rmii_rxd(rmii_rxd), .rmii_crs_dv(rmii_crs_dv),
      .received_byte(rb_a), .byte_valid(bv_a), .frame_end(fe_a),
      .frame_len(len_a), .rx_error(err_a)
   );

   rmii_rx #(.MIN_PREAMBLE_DIBITS(MIN_PRE), .MAX_FRAME_BYTES(MAX_B)) dut_b (
      .clk(clk), .reset(reset), .rmii_rxd(rmii_rxd), .rmii_crs_dv(rmii_crs_dv),
      .received_byte(rb_b), .byte_valid(bv_b), .frame_end(fe_b),
      .frame_len(len_b), .rx_error(err_b)
   );

   always #10 clk = ~clk;

   // Stimulus: one entry per rising edge.
   logic       s_dv  [N_MAX];
   logic [1:0] s_rxd [N_MAX];
   logic       s_rst [N_MAX];
   int         n_samp = 0;

   // Expected outputs per instance and slot (slot t = state just after edge t).
   logic        e_bv   [2][N_MAX];
   logic        e_fe   [2][N_MAX];
   logic        e_err  [2][N_MAX];
   logic [7:0]  e_byte [2][N_MAX];
   logic [15:0] e_len  [2][N_MAX];
   logic [7:0]  h_byte [2][N_MAX];
   logic [15:0] h_len  [2][N_MAX];

   logic [1:0]  b_rxd  [$];
   int          b_slot [$];

   int n_checks = 0;
   int n_errors = 0;
   bit running  = 1'b0;
   int cur      = 0;

   int o_bv  [2] = '{0, 0};
   int o_nfe [2] = '{0, 0};
   int o_len [2][16];
   int o_err [2][16];
   int m_bv  [2] = '{0, 0};
   int m_nfe [2] = '{0, 0};
   int m_len [2][16];
   int m_err [2][16];

   int lit_len [2][6] = '{'{64, 64, 16, 20, 20, 8}, '{16, 16, 16, 16, 16, 8}};
   int lit_err [2][6] = '{'{0, 0, 0, 1, 0, 0},      '{1, 1, 0, 1, 1, 0}};
   int lit_bv  [2]    = '{209, 105};

   task automatic chk(input string name, input int inst, input int t,
                      input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s dut%0d slot %0d: got %0h expected %0h", name, inst, t, act, exp);
      end
   endtask

   task automatic push(input logic dv, input logic [1:0] d);
      if (n_samp < N_MAX) begin
         s_dv[n_samp]  = dv;
         s_rxd[n_samp] = d;
         s_rst[n_samp] = 1'b0;
         n_samp++;
      end
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) push(1'b0, 2'b00);
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 0; i < 4; i++) push(1'b1, b[2*i +: 2]);
   endtask

   task automatic push_header(input int npre);
      for (int i = 0; i < 3; i++) push(1'b1, 2'b00);
      for (int i = 0; i < npre; i++) push(1'b1, 2'b01);
      push(1'b1, 2'b11);
   endtask

   task automatic push_frame(input int npre, input int nbytes, input logic [7:0] base);
      push_header(npre);
      for (int i = 0; i < nbytes; i++) push_byte(base + 8'(i));
   endtask

   task automatic build_stimulus();
      int rst_at;
      push_idle(4);
      push_frame(31, 64, 8'h00);                  // clean frame
      push_idle(4);
      push_frame(31, 64, 8'h00);                  // end toggling
      for (int j = 0; j < 8; j++) s_dv[n_samp-8+j] = (j % 2 == 1);
      push_idle(4);
      push_frame(10, 8, 8'h40);                   // short preamble
      push_idle(4);
      push_frame(11, 4, 8'h50);                   // one below minimum
      push_idle(4);
      push_frame(12, 16, 8'h60);                  // exactly minimum
      push_idle(4);
      push_frame(31, 20, 8'h80);                  // alignment error
      push(1'b1, 2'b10);
      push(1'b1, 2'b01);
      push_idle(4);
      push_frame(31, 20, 8'h90);                  // overflow on the 16-byte instance
      push_idle(4);
      push_header(15);                            // reset mid-frame
      for (int i = 0; i < 10; i++) push_byte(8'hA0 + 8'(i));
      rst_at = n_samp + 1;
      for (int i = 10; i < 16; i++) push_byte(8'h55);
      push_byte(8'hFD);
      for (int i = 17; i < 30; i++) push_byte(8'(i));
      s_rst[rst_at] = 1'b1;
      push_idle(4);
      push_frame(31, 8, 8'hC0);                   // recovery
      push_idle(8);
   endtask

   // Decode one carrier burst of present dibits: skip to the 01 run, require 11 after
   // enough 01s, then group the rest in fours.
   task automatic decode_burst(input int inst, input int max_b, input int end_slot, input bit has_end);
      int p, run, q, nd, nb, v, s;
      p = 0;
      run = 0;
      while (p < b_rxd.size() && b_rxd[p] != 2'b01) p++;
      while (p + run < b_rxd.size() && b_rxd[p+run] == 2'b01) run++;
      if (run == 0 || p + run >= b_rxd.size()) return;
      if (b_rxd[p+run] != 2'b11 || run < MIN_PRE) return;
      e_bv[inst][b_slot[p+run]]   = 1'b1;
      e_byte[inst][b_slot[p+run]] = 8'hD5;
      q  = p + run + 1;
      nd = b_rxd.size() - q;
      nb = nd / 4;
      for (int b = 0; b < nb; b++) begin
         s = b_slot[q + 4*b + 3];
         if (b == max_b) begin
            e_fe[inst][s]  = 1'b1;
            e_err[inst][s] = 1'b1;
            e_len[inst][s] = 16'(max_b);
            return;
         end
         v = 0;
         for (int j = 0; j < 4; j++) v += int'(b_rxd[q + 4*b + j]) << (2*j);
         e_bv[inst][s]   = 1'b1;
         e_byte[inst][s] = 8'(v);
      end
      if (has_end) begin
         e_fe[inst][end_slot]  = 1'b1;
         e_err[inst][end_slot] = (nd % 4) != 0;
         e_len[inst][end_slot] = 16'(nb);
      end
   endtask

   task automatic run_model(input int inst, input int max_b);
      bit         dropped;
      logic       pdv;
      logic [1:0] prxd;
      logic [7:0] hb;
      logic [15:0] hl;
      for (int t = 0; t < N_MAX; t++) begin
         e_bv[inst][t] = 1'b0; e_fe[inst][t] = 1'b0; e_err[inst][t] = 1'b0;
         e_byte[inst][t] = 8'h00; e_len[inst][t] = 16'h0000;
      end
      b_rxd.delete();
      b_slot.delete();
      dropped = 1'b1;
      for (int t = 0; t < n_samp; t++) begin
         if (s_rst[t]) begin
            if (!dropped) decode_burst(inst, max_b, 0, 1'b0);
            b_rxd.delete();
            b_slot.delete();
            dropped = 1'b1;
            continue;
         end
         if (t == 0 || s_rst[t-1]) begin
            pdv = 1'b0; prxd = 2'b00;
         end else begin
            pdv = s_dv[t-1]; prxd = s_rxd[t-1];
         end
         if (!pdv && !s_dv[t]) begin
            if (!dropped) decode_burst(inst, max_b, t, 1'b1);
            b_rxd.delete();
            b_slot.delete();
            dropped = 1'b0;
         end else if (!dropped) begin
            b_rxd.push_back(prxd);
            b_slot.push_back(t);
         end
      end
      hb = 8'h00;
      hl = 16'h0000;
      for (int t = 0; t < n_samp; t++) begin
         if (s_rst[t]) begin
            hb = 8'h00; hl = 16'h0000;
         end else begin
            if (e_bv[inst][t]) hb = e_byte[inst][t];
            if (e_fe[inst][t]) hl = e_len[inst][t];
         end
         h_byte[inst][t] = hb;
         h_len[inst][t]  = hl;
         if (e_bv[inst][t]) m_bv[inst]++;
         if (e_fe[inst][t]) begin
            if (m_nfe[inst] < 16) begin
               m_len[inst][m_nfe[inst]] = int'(e_len[inst][t]);
               m_err[inst][m_nfe[inst]] = int'(e_err[inst][t]);
            end
            m_nfe[inst]++;
         end
      end
   endtask

   task automatic check_slot(input int inst, input int t, input logic bv, input logic fe,
                             input logic er, input logic [7:0] rb, input logic [15:0] fl);
      chk("byte_valid",    inst, t, 16'(bv), 16'(e_bv[inst][t]));
      chk("frame_end",     inst, t, 16'(fe), 16'(e_fe[inst][t]));
      chk("rx_error",      inst, t, 16'(er), 16'(e_err[inst][t]));
      chk("received_byte", inst, t, 16'(rb), 16'(h_byte[inst][t]));
      chk("frame_len",     inst, t, fl,      h_len[inst][t]);
      if (bv) o_bv[inst]++;
      if (fe) begin
         if (o_nfe[inst] < 16) begin
            o_len[inst][o_nfe[inst]] = int'(fl);
            o_err[inst][o_nfe[inst]] = int'(er);
         end
         o_nfe[inst]++;
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (running && cur < n_samp) begin
         check_slot(0, cur, bv_a, fe_a, err_a, rb_a, len_a);
         check_slot(1, cur, bv_b, fe_b, err_b, rb_b, len_b);
         cur++;
      end
   end

   initial begin
      reset       = 1'b1;
      rmii_rxd    = 2'b00;
      rmii_crs_dv = 1'b0;
      build_stimulus();
      run_model(0, MAX_A);
      run_model(1, MAX_B);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_byte_valid", 0, -1, 16'(bv_a), 16'd0);
      chk("reset_frame_end",  0, -1, 16'(fe_a), 16'd0);
      chk("reset_frame_len",  0, -1, len_a,     16'd0);
      chk("reset_byte",       1, -1, 16'(rb_b), 16'd0);
      chk("reset_rx_error",   1, -1, 16'(err_b), 16'd0);

      for (int k = 0; k < n_samp; k++) begin
         rmii_crs_dv = s_dv[k];
         rmii_rxd    = s_rxd[k];
         reset       = s_rst[k];
         if (k == 0) running = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      #5;

      for (int i = 0; i < 2; i++) begin
         chk("model_bv_count", i, -1, 16'(m_bv[i]),  16'(lit_bv[i]));
         chk("dut_bv_count",   i, -1, 16'(o_bv[i]),  16'(lit_bv[i]));
         chk("model_fe_count", i, -1, 16'(m_nfe[i]), 16'd6);
         chk("dut_fe_count",   i, -1, 16'(o_nfe[i]), 16'd6);
         for (int j = 0; j < 6; j++) begin
            chk("model_fe_len", i, j, 16'(m_len[i][j]), 16'(lit_len[i][j]));
            chk("model_fe_err", i, j, 16'(m_err[i][j]), 16'(lit_err[i][j]));
            chk("dut_fe_len",   i, j, 16'(o_len[i][j]), 16'(lit_len[i][j]));
            chk("dut_fe_err",   i, j, 16'(o_err[i][j]), 16'(lit_err[i][j]));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
